ofsram_arbiter: RTL and testbench
=================================

Name: ofsram_arbiter

Overview:
- Shares the single off-chip SRAM port between two requesters: port 0, the flash-side off-chip SRAM path, and port 1, the host/maintenance path (preload, readback, scrub).
- Sits between both requesters and the off-chip SRAM pins; drives OFAdd/OFRead/OFWrite/OFDataout and routes OFDatain back to the owner.
- Arbitration: round-robin, burst-limited ownership, with a mandatory dead cycle on handoff so in-flight reads drain.

Parameters:
ADDR_W, 17, SRAM word address width
DATA_W, 16, SRAM data width
MAX_BURST, 64, accesses an owner may issue before losing the grant when the other port is requesting (range 1..255)

Ports:
clk2  in  1  single system clock; all logic on rising edge
NReset  in  1  synchronous, active-low reset
req0 / req1  in  1  port requests ownership; held high for whole transaction
rd0 / rd1  in  1  read strobe, honoured only while matching gnt high
wr0 / wr1  in  1  write strobe, honoured only while matching gnt high
addr0 / addr1  in  ADDR_W  access address
wdata0 / wdata1  in  DATA_W  write data
gnt0 / gnt1  out  1  ownership grant, registered; never both high
rvalid0 / rvalid1  out  1  one-cycle read-data-valid pulse to the issuing port
rdata0 / rdata1  out  DATA_W  read data, valid with rvalid
OFAdd  out  ADDR_W  SRAM address, registered
OFRead  out  1  SRAM read strobe, registered
OFWrite  out  1  SRAM write strobe, registered
OFDataout  out  DATA_W  SRAM write data, registered
OFDatain  in  DATA_W  SRAM read data, valid one cycle after OFRead
busy  out  1  high in any state other than IDLE
owner  out  1  last/current owner index (0 or 1)

Behaviour:
- Reset: when NReset is sampled low at a clk2 edge, all outputs go to 0 on that edge; owner = 1, so port 0 wins the first tie; state = IDLE.
- Reset during a transaction: any pending read is discarded; no rvalid is generated.
- States and transitions:
  - IDLE: at least one req seen → OWN0 or OWN1; gnt rises the next cycle.
  - Tie in IDLE: the port that is not `owner` wins.
  - OWN0 / OWN1, on each cycle with gnt_x && (rd_x || wr_x):
    - register addr_x → OFAdd;
    - assert OFRead or OFWrite for one cycle;
    - if wr: wdata_x → OFDataout;
    - increment the burst counter.
  - rd_x && wr_x together: the write is performed; the read is ignored.
  - Leaving OWNx: on req_x low, or on (burst count == MAX_BURST && other req high) → HANDOFF.
  - When leaving, gnt_x drops the cycle after the condition is seen; strobes in that cycle are ignored.
  - HANDOFF: exactly one cycle with both gnt low; drains the last read's OFDatain. Then → IDLE, and IDLE re-arbitrates the next cycle.
  - Burst limit reached but other req low: the counter saturates at MAX_BURST and the owner keeps the grant.
- Read latency:
  - rd_x at cycle N → OFRead at N+1 → OFDatain captured at N+2 → rvalid_x/rdata_x at N+2.
  - Pipelined reads sustain one per cycle.
- Write latency: wr_x at N → OFWrite/OFAdd/OFDataout at N+1.
- Burst counter: 8 bits; clears on entry to OWNx; saturates at MAX_BURST.
- Idle outputs: OFRead/OFWrite are low whenever no honoured strobe occurred in the previous cycle; OFAdd/OFDataout hold their last values.
- Grant-to-grant gap between different owners: at least 2 cycles (drop cycle + HANDOFF).

Optional Feature:
OFSRAM_ARB_PRIO0_EN
- Defined:
  - port 0 always wins IDLE ties;
  - port 0 is never burst-preempted;
  - port 1 is preempted after MAX_BURST even if port 0 is not requesting only when req0 rises, with HANDOFF as normal.
- Undefined: pure round-robin as above.

Decomposition:
- Package ofsram_arb_pkg holds:
  - state enum {IDLE, OWN0, OWN1, HANDOFF};
  - owner encoding constants PORT_FLASH = 0, PORT_HOST = 1;
  - BURST_CNT_W = 8.
- One sub-module, ofsram_arb_burstcnt: clear / increment / saturate-at-limit counter; outputs limit_hit.
- Port mux and read-return routing stay in the top.

Test Plan:
- Reset then req0 only, rd0 at addr 0x00010 → gnt0 at +1; OFRead with OFAdd = 0x00010 one cycle after rd0; rvalid0 with rdata0 = OFDatain two cycles after rd0; rvalid1 stays 0.
- req0 and req1 rise together from reset → gnt0 first; after req0 drops: one gnt-drop cycle, one HANDOFF cycle, then gnt1; next simultaneous tie goes to port 1's opposite (port 0) only when owner = 1.
- MAX_BURST = 4, port 1 owns with continuous wr1 and req0 high → exactly 4 OFWrite pulses, then gnt1 low, HANDOFF, gnt0. With req0 low instead, the writes continue beyond 4.
- rd1 and wr1 asserted together, addr 0x1FFFF, wdata 0xA5A5 → OFWrite = 1, OFRead = 0, OFDataout = 0xA5A5, no rvalid1.
- NReset low for one edge, the cycle after rd0 → OFRead, gnt0, busy all 0 after that edge; no rvalid0 ever appears for that read; owner = 1.
- With OFSRAM_ARB_PRIO0_EN, MAX_BURST = 2 → port 0 issues 10 consecutive reads without losing gnt0 while req1 is high; tie from IDLE always goes to port 0.

Source files
------------

// File: rtl/ofsram_arb_pkg.sv
// Shared types and constants for the off-chip SRAM port arbiter.
package ofsram_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, HANDOFF} state_e;

    localparam logic PORT_FLASH  = 1'b0;
    localparam logic PORT_HOST   = 1'b1;
    localparam int   BURST_CNT_W = 8;

endpackage

// File: rtl/ofsram_arbiter_if.sv
// Requester-side bundle of the off-chip SRAM arbiter; one instance per port.
interface ofsram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              req;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, rd, wr, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, rd, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ofsram_arb_burstcnt.sv
// Per-ownership access counter: clears on entry, counts honoured accesses,
// saturates at LIMIT and flags limit_hit.
module ofsram_arb_burstcnt
    import ofsram_arb_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic clk2,
    input  logic NReset,
    input  logic clr,
    input  logic inc,
    output logic limit_hit
);
    logic [BURST_CNT_W-1:0] cnt;

    assign limit_hit = (cnt == BURST_CNT_W'(LIMIT));

    always_ff @(posedge clk2) begin
        if (!NReset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !limit_hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ofsram_arbiter.sv
// Round-robin, burst-limited arbiter sharing the off-chip SRAM pins between
// the flash path (port0) and host path (port1). Optional: OFSRAM_ARB_PRIO0_EN.
module ofsram_arbiter
    import ofsram_arb_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 64
) (
    input  logic              clk2,
    input  logic              NReset,
    ofsram_arbiter_if.slave   port0,
    ofsram_arbiter_if.slave   port1,
    output logic [ADDR_W-1:0] OFAdd,
    output logic              OFRead,
    output logic              OFWrite,
    output logic [DATA_W-1:0] OFDataout,
    input  logic [DATA_W-1:0] OFDatain,
    output logic              busy,
    output logic              owner
);
    localparam int NUM_PORTS = 2;
    localparam int STAGES    = 1;

    logic [NUM_PORTS-1:0]             req, rd, wr, gnt, rvalid;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, rdata;

    state_e      state, state_nxt;
    logic        cur, leave, issue, rd_issue, limit_hit;
    logic        tie_pick, preempt_ok;
    logic [STAGES:0] vld_pipe, port_pipe;

    assign req   = {port1.req,   port0.req};
    assign rd    = {port1.rd,    port0.rd};
    assign wr    = {port1.wr,    port0.wr};
    assign addr  = {port1.addr,  port0.addr};
    assign wdata = {port1.wdata, port0.wdata};

    assign port0.gnt    = gnt[0];
    assign port1.gnt    = gnt[1];
    assign port0.rvalid = rvalid[0];
    assign port1.rvalid = rvalid[1];
    assign port0.rdata  = rdata[0];
    assign port1.rdata  = rdata[1];

`ifdef OFSRAM_ARB_PRIO0_EN
    assign tie_pick   = PORT_FLASH;
    assign preempt_ok = (state == OWN1);
`else
    assign tie_pick   = ~owner;
    assign preempt_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        leave     = 1'b0;
        cur       = (state == OWN1) ? PORT_HOST : PORT_FLASH;
        case (state)
            IDLE: begin
                if (req[0] && req[1])
                    state_nxt = (tie_pick == PORT_HOST) ? OWN1 : OWN0;
                else if (req[0])
                    state_nxt = OWN0;
                else if (req[1])
                    state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                leave = !req[cur] || (limit_hit && req[~cur] && preempt_ok);
                if (leave)
                    state_nxt = HANDOFF;
            end
            HANDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes in the cycle the grant is being withdrawn are dropped.
    assign issue    = (state == OWN0 || state == OWN1) && (rd[cur] || wr[cur]) && !leave;
    assign rd_issue = issue && !wr[cur];
    assign busy     = (state != IDLE);

    ofsram_arb_burstcnt #(.LIMIT(MAX_BURST)) u_burstcnt (
        .clk2      (clk2),
        .NReset    (NReset),
        .clr       (state == IDLE),
        .inc       (issue),
        .limit_hit (limit_hit)
    );

    always_ff @(posedge clk2) begin
        if (!NReset) begin
            state     <= IDLE;
            owner     <= PORT_HOST;
            gnt       <= '0;
            OFAdd     <= '0;
            OFRead    <= 1'b0;
            OFWrite   <= 1'b0;
            OFDataout <= '0;
            vld_pipe  <= '0;
            port_pipe <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= {state_nxt == OWN1, state_nxt == OWN0};
            if (state == IDLE && state_nxt != IDLE)
                owner <= (state_nxt == OWN1) ? PORT_HOST : PORT_FLASH;
            OFRead  <= rd_issue;
            OFWrite <= issue && wr[cur];
            if (issue)
                OFAdd <= addr[cur];
            if (issue && wr[cur])
                OFDataout <= wdata[cur];
            // Read tag travels with the request so a drain during HANDOFF still routes.
            vld_pipe  <= {vld_pipe[STAGES-1:0], rd_issue};
            port_pipe <= {port_pipe[STAGES-1:0], cur};
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ret
        assign rvalid[p] = vld_pipe[STAGES] && (port_pipe[STAGES] == 1'(p));
        assign rdata[p]  = rvalid[p] ? OFDatain : '0;
    end

endmodule

// File: tb/tb_ofsram_arbiter.sv
// Directed bench for ofsram_arbiter with a one-cycle-latency SRAM model.
module tb_ofsram_arbiter;
`ifdef OFSRAM_ARB_PRIO0_EN
    localparam int MB = 2;
`else
    localparam int MB = 4;
`endif

    logic        clk2, NReset;
    logic [16:0] OFAdd;
    logic        OFRead, OFWrite, busy, owner;
    logic [15:0] OFDataout, OFDatain;
    int          n_chk = 0, n_fail = 0;

    ofsram_arbiter_if #(.ADDR_W(17), .DATA_W(16)) p0_if ();
    ofsram_arbiter_if #(.ADDR_W(17), .DATA_W(16)) p1_if ();

    ofsram_arbiter #(.ADDR_W(17), .DATA_W(16), .MAX_BURST(MB)) dut (
        .clk2(clk2), .NReset(NReset), .port0(p0_if), .port1(p1_if),
        .OFAdd(OFAdd), .OFRead(OFRead), .OFWrite(OFWrite), .OFDataout(OFDataout),
        .OFDatain(OFDatain), .busy(busy), .owner(owner)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    function automatic logic [15:0] mem(input logic [16:0] a);
        return a[15:0] ^ {15'b0, a[16]} ^ 16'h5A3C;
    endfunction

    always @(posedge clk2) if (OFRead) OFDatain <= mem(OFAdd);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic idle_inputs();
        p0_if.req = 1'b0; p0_if.rd = 1'b0; p0_if.wr = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
        p1_if.req = 1'b0; p1_if.rd = 1'b0; p1_if.wr = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;
    endtask

    task automatic do_reset();
        NReset = 1'b0;
        idle_inputs();
        tick();
        tick();
        NReset = 1'b1;
    endtask

    int wcnt, first, ovl, rcnt, gcnt;

    initial begin
        OFDatain = '0;
        do_reset();
        chk("rst_gnt", 32'({p1_if.gnt, p0_if.gnt}), 32'd0);
        chk("rst_strobes", 32'({OFRead, OFWrite}), 32'd0);
        chk("rst_ofadd", 32'(OFAdd), 32'd0);
        chk("rst_ofdout", 32'(OFDataout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_rvalid", 32'({p1_if.rvalid, p0_if.rvalid}), 32'd0);

        // Single + pipelined reads on port 0
        p0_if.req = 1'b1;
        tick();
        chk("rd_gnt0", 32'(p0_if.gnt), 32'd1);
        chk("rd_owner0", 32'(owner), 32'd0);
        for (int k = 0; k < 5; k++) begin
            p0_if.rd   = (k < 3);
            p0_if.addr = 17'(16 + k);
            tick();
            chk("rd_ofread", 32'(OFRead), 32'(k < 3));
            if (k < 3) chk("rd_ofadd", 32'(OFAdd), 32'(16 + k));
            chk("rd_rvalid0", 32'(p0_if.rvalid), 32'(k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) chk("rd_rdata0", 32'(p0_if.rdata), 32'(mem(17'(15 + k))));
            chk("rd_rvalid1", 32'(p1_if.rvalid), 32'd0);
        end
        p0_if.req = 1'b0;
        tick();
        chk("rd_handoff_gnt0", 32'(p0_if.gnt), 32'd0);
        chk("rd_handoff_busy", 32'(busy), 32'd1);
        tick();
        chk("rd_idle_busy", 32'(busy), 32'd0);

        // Tie arbitration and handoff gap
        do_reset();
        p0_if.req = 1'b1; p1_if.req = 1'b1;
        tick();
        chk("tie0_gnt", 32'({p1_if.gnt, p0_if.gnt}), 32'b01);
        tick();
        p0_if.req = 1'b0;
        tick();
        chk("ho_gnt_low1", 32'({p1_if.gnt, p0_if.gnt}), 32'b00);
        tick();
        chk("ho_gnt_low2", 32'({p1_if.gnt, p0_if.gnt}), 32'b00);
        tick();
        chk("ho_gnt1", 32'({p1_if.gnt, p0_if.gnt}), 32'b10);
        chk("ho_owner1", 32'(owner), 32'd1);
        p1_if.req = 1'b0;
        tick(); tick();
        p0_if.req = 1'b1; p1_if.req = 1'b1;
        tick();
        chk("tie_after1_gnt", 32'({p1_if.gnt, p0_if.gnt}), 32'b01);
        p0_if.req = 1'b0; p1_if.req = 1'b0;
        tick(); tick();
        p0_if.req = 1'b1; p1_if.req = 1'b1;
        tick();
`ifdef OFSRAM_ARB_PRIO0_EN
        chk("tie_prio_gnt", 32'({p1_if.gnt, p0_if.gnt}), 32'b01);
        // Port 0 never burst-preempted
        p1_if.req = 1'b1;
        rcnt = 0; gcnt = 0;
        for (int k = 0; k < 10; k++) begin
            p0_if.rd = 1'b1; p0_if.addr = 17'(k);
            tick();
            rcnt += int'(OFRead);
            gcnt += int'(p0_if.gnt);
        end
        p0_if.rd = 1'b0;
        chk("prio_reads", 32'(rcnt), 32'd10);
        chk("prio_gnt0_held", 32'(gcnt), 32'd10);
`else
        chk("tie_after0_gnt", 32'({p1_if.gnt, p0_if.gnt}), 32'b10);
`endif

        // Burst limit with port 0 waiting
        do_reset();
        p1_if.req = 1'b1;
        tick();
        chk("bl_gnt1", 32'(p1_if.gnt), 32'd1);
        p0_if.req = 1'b1; p1_if.wr = 1'b1; p1_if.addr = 17'h200; p1_if.wdata = 16'h1111;
        wcnt = 0; first = -1; ovl = 0;
        for (int i = 1; i <= MB + 6; i++) begin
            tick();
            wcnt += int'(OFWrite);
            if (p0_if.gnt && first < 0) first = i;
            if (p0_if.gnt && p1_if.gnt) ovl++;
        end
        chk("bl_writes", 32'(wcnt), 32'(MB));
        chk("bl_gnt0_cycle", 32'(first), 32'(MB + 3));
        chk("bl_no_overlap", 32'(ovl), 32'd0);

        // Saturation: no contender, writes continue past the limit
        do_reset();
        p1_if.req = 1'b1;
        tick();
        p1_if.wr = 1'b1; p1_if.wdata = 16'h2222;
        wcnt = 0;
        for (int k = 0; k < 10; k++) begin
            p1_if.addr = 17'(12'h300 + k);
            tick();
            wcnt += int'(OFWrite);
        end
        chk("sat_writes", 32'(wcnt), 32'd10);
        chk("sat_gnt1", 32'(p1_if.gnt), 32'd1);
        chk("sat_ofadd", 32'(OFAdd), 32'h309);
        p0_if.req = 1'b1;
        tick();
        chk("sat_preempt_wr", 32'(OFWrite), 32'd0);
        chk("sat_preempt_gnt1", 32'(p1_if.gnt), 32'd0);

        // rd and wr together: write wins
        do_reset();
        p1_if.req = 1'b1;
        tick();
        p1_if.rd = 1'b1; p1_if.wr = 1'b1; p1_if.addr = 17'h1FFFF; p1_if.wdata = 16'hA5A5;
        tick();
        chk("rw_ofwrite", 32'(OFWrite), 32'd1);
        chk("rw_ofread", 32'(OFRead), 32'd0);
        chk("rw_ofdout", 32'(OFDataout), 32'hA5A5);
        chk("rw_ofadd", 32'(OFAdd), 32'h1FFFF);
        p1_if.rd = 1'b0; p1_if.wr = 1'b0;
        tick();
        chk("rw_rvalid1_a", 32'(p1_if.rvalid), 32'd0);
        tick();
        chk("rw_rvalid1_b", 32'(p1_if.rvalid), 32'd0);

        // Reset with a read in flight
        do_reset();
        p0_if.req = 1'b1;
        tick();
        p0_if.rd = 1'b1; p0_if.addr = 17'h123;
        tick();
        chk("mr_ofread", 32'(OFRead), 32'd1);
        NReset = 1'b0; p0_if.rd = 1'b0; p0_if.req = 1'b0;
        tick();
        chk("mr_ofread_clr", 32'(OFRead), 32'd0);
        chk("mr_gnt0", 32'(p0_if.gnt), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_owner", 32'(owner), 32'd1);
        NReset = 1'b1;
        rcnt = int'(p0_if.rvalid);
        for (int k = 0; k < 3; k++) begin
            tick();
            rcnt += int'(p0_if.rvalid);
        end
        chk("mr_no_rvalid", 32'(rcnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
